// File: rtl/step_clock_ctrl_if.sv
// Handshake bundle between the board-side controls and the CPU clock generator.
// The master drives the divider clock and raw controls; the slave returns the CPU clock and status.
interface step_clock_ctrl_if;
    logic        div_clk;
    logic        run_sw;
    logic        step_btn;
    logic        cpu_clk;
    logic [31:0] cycle_cnt;
    logic [1:0]  mode;

    modport master (
        output div_clk,
        output run_sw,
        output step_btn,
        input  cpu_clk,
        input  cycle_cnt,
        input  mode
    );

    modport slave (
        input  div_clk,
        input  run_sw,
        input  step_btn,
        output cpu_clk,
        output cycle_cnt,
        output mode
    );
endinterface

// File: rtl/step_clock_ctrl.sv
// CPU clock source: free-runs from the divider clock or emits single debounced step pulses.
// Every output comes straight from a flop; reset clears all state asynchronously.
module step_clock_ctrl #(
    parameter int DB_CYCLES   = 500000,
    parameter int HIGH_CYCLES = 4
) (
    input  logic              clk_in,
    input  logic              reset,
    step_clock_ctrl_if.slave  if_ctrl
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int PC_W = $clog2(HIGH_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_LOAD = PC_W'(HIGH_CYCLES);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PULSE = 2'b10
    } state_t;

    // Index 0 is the run switch, index 1 the step button.
    logic [1:0] w_raw;
    logic [1:0] w_stable;

    assign w_raw = {if_ctrl.step_btn, if_ctrl.run_sw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_db
            logic            r_sync1;
            logic            r_sync2;
            logic            r_stable;
            logic [DB_W-1:0] r_db_cnt;

            always_ff @(posedge clk_in or posedge reset) begin
                if (reset) begin
                    r_sync1  <= 1'b0;
                    r_sync2  <= 1'b0;
                    r_stable <= 1'b0;
                    r_db_cnt <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_stable) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_stable <= r_sync2;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end

            assign w_stable[gi] = r_stable;
        end
    endgenerate

    logic w_run;
    logic w_step_req;
    logic r_step_prev;
    logic r_div_q;
    logic w_div_rise;
    logic w_div_fall;

    assign w_run      = w_stable[0];
    assign w_step_req = w_stable[1] & ~r_step_prev;
    assign w_div_rise = if_ctrl.div_clk & ~r_div_q;
    assign w_div_fall = ~if_ctrl.div_clk & r_div_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_step_prev <= 1'b0;
            r_div_q     <= 1'b0;
        end else begin
            r_step_prev <= w_stable[1];
            r_div_q     <= if_ctrl.div_clk;
        end
    end

    state_t          r_state;
    state_t          w_state_next;
    logic            r_cpu_clk;
    logic            w_cpu_clk_next;
    logic [PC_W-1:0] r_pulse_cnt;
    logic [PC_W-1:0] w_pulse_cnt_next;
    logic [31:0]     r_cycle_cnt;
    logic [31:0]     w_cycle_cnt_next;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cpu_clk   <= 1'b0;
            r_pulse_cnt <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cpu_clk   <= w_cpu_clk_next;
            r_pulse_cnt <= w_pulse_cnt_next;
            r_cycle_cnt <= w_cycle_cnt_next;
        end
    end

    // A pending stop in RUN waits for the divider fall so the last high phase is never clipped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_run) begin
                    w_state_next = ST_RUN;
                end else if (w_step_req) begin
                    w_state_next = ST_PULSE;
                end
            end
            ST_RUN: begin
                if (!w_run && (!r_cpu_clk || w_div_fall)) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_PULSE: begin
                if (r_pulse_cnt <= PC_ONE) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cpu_clk_next   = r_cpu_clk;
        w_pulse_cnt_next = r_pulse_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cpu_clk_next = 1'b0;
                if (!w_run && w_step_req) begin
                    w_cpu_clk_next   = 1'b1;
                    w_pulse_cnt_next = PC_LOAD;
                end
            end
            ST_RUN: begin
                if (!w_run && !r_cpu_clk) begin
                    w_cpu_clk_next = 1'b0;
                end else if (w_div_rise) begin
                    w_cpu_clk_next = 1'b1;
                end else if (w_div_fall) begin
                    w_cpu_clk_next = 1'b0;
                end
            end
            ST_PULSE: begin
                if (r_pulse_cnt <= PC_ONE) begin
                    w_cpu_clk_next   = 1'b0;
                    w_pulse_cnt_next = '0;
                end else begin
                    w_cpu_clk_next   = 1'b1;
                    w_pulse_cnt_next = r_pulse_cnt - 1'b1;
                end
            end
            default: begin
                w_cpu_clk_next   = 1'b0;
                w_pulse_cnt_next = '0;
            end
        endcase
        w_cycle_cnt_next = r_cycle_cnt + {31'd0, w_cpu_clk_next & ~r_cpu_clk};
    end

    assign if_ctrl.cpu_clk   = r_cpu_clk;
    assign if_ctrl.mode      = r_state;
    assign if_ctrl.cycle_cnt = r_cycle_cnt;

endmodule

// File: doc/step_clock_ctrl.md
STEP_CLOCK_CTRL -- requirements
Module: step_clock_ctrl

Interface
REQ-001: Parameter DB_CYCLES, default 500000, is the number of consecutive clk_in cycles an input must hold a new level before it is accepted as debounced.
REQ-002: Parameter HIGH_CYCLES, default 4, is the cpu_clk high time, in clk_in cycles, of a single-step pulse.
REQ-003: clk_in  input  1  board clock; the only clock of the block.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: div_clk  input  1  slow square wave from the clock divider; generated in the clk_in domain.
REQ-006: run_sw  input  1  raw slide switch, asynchronous; 1 = free-run, 0 = single-step.
REQ-007: step_btn  input  1  raw push button, asynchronous and bouncing; press = 1.
REQ-008: cpu_clk  output  1  registered CPU clock.
REQ-009: cycle_cnt  output  32  count of cpu_clk rising transitions.
REQ-010: mode  output  2  current FSM state: 00 IDLE, 01 RUN, 10 PULSE.

Function
REQ-011: run_sw and step_btn SHALL each pass through a two-flop synchronizer before any other use.
REQ-012: Each synchronized input SHALL have its own debouncer.
- Counter clears in any cycle where the synchronized value equals the stable value.
- Otherwise the counter increments.
- When the count reaches DB_CYCLES-1, the stable value takes the synchronized value and the counter clears.
REQ-013: The stable step value SHALL produce step_req, a one-cycle pulse, on its 0->1 transition only; release produces nothing.
REQ-014: div_clk SHALL be registered once (div_q).
- Rise event = div_clk & ~div_q.
- Fall event = ~div_clk & div_q.
REQ-015: In IDLE:
- cpu_clk = 0.
- stable run = 1 -> RUN.
- else step_req -> PULSE, with pulse counter loaded to HIGH_CYCLES.
REQ-016: In RUN:
- cpu_clk <= 1 on a rise event and <= 0 on a fall event.
- Otherwise cpu_clk holds its value.
- cpu_clk therefore lags div_clk by exactly one clk_in cycle.
REQ-017: Entering RUN SHALL NOT produce a partial high phase; cpu_clk stays 0 until the first rise event after entry.
REQ-018: In RUN with stable run = 0:
- If cpu_clk = 0, go to IDLE on the next edge.
- If cpu_clk = 1, stay in RUN until the fall event, then go to IDLE with cpu_clk = 0 on the same edge.
REQ-019: In PULSE:
- cpu_clk = 1 for exactly HIGH_CYCLES clk_in cycles starting the cycle after step_req.
- Then cpu_clk = 0 and the state returns to IDLE.
REQ-020: step_req SHALL be ignored (dropped, not queued) in RUN and PULSE.
REQ-021: If stable run rises in the same cycle as step_req in IDLE, RUN SHALL win and the step SHALL be dropped.
REQ-022: A change of run_sw during PULSE SHALL NOT shorten the pulse; it is evaluated on return to IDLE.
REQ-023: cycle_cnt SHALL increment by 1 on every cycle in which cpu_clk goes 0->1.
- Applies in both RUN and PULSE.
- Wraps from 0xFFFFFFFF to 0 with no flag.
REQ-024: cpu_clk, mode and cycle_cnt SHALL be driven directly from flops (no combinational output paths).

Reset
REQ-025: On reset assertion, all of the following SHALL clear immediately and asynchronously, regardless of state: cpu_clk 0, cycle_cnt 0, mode 00 (IDLE), synchronizers, stable values, debounce counters, pulse counter and div_q.
REQ-026: After reset deassertion, a held step_btn or run_sw SHALL be honoured only after a full DB_CYCLES debounce period.

Verification (bench uses DB_CYCLES=4, HIGH_CYCLES=3, div_clk 4 high / 4 low)
REQ-027: step_btn glitch of 2 cycles, then 0 -> cpu_clk stays 0, cycle_cnt = 0, mode = 00 throughout.
REQ-028: step_btn held 1 for 12 cycles -> after 2 sync + 4 debounce cycles, exactly one pulse: cpu_clk high 3 cycles, cycle_cnt = 1, mode 00->10->00.
REQ-029: second clean press while cpu_clk is high in PULSE -> pulse length still 3, cycle_cnt = 1 (press dropped).
REQ-030: run_sw = 1 for 40 cycles -> cpu_clk is div_clk delayed by 1 cycle, no partial first phase, cycle_cnt increments once per 8-cycle period.
REQ-031: run_sw dropped while cpu_clk = 1 -> cpu_clk remains 1 until the div_clk fall plus 1 cycle, then mode = 00 and cpu_clk = 0; no further increments.
REQ-032: reset asserted in the 2nd high cycle of a PULSE -> cpu_clk = 0, cycle_cnt = 0, mode = 00 immediately, without waiting for a clk_in edge.
